// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_e  : sequencer states (RUN, MEM_WAIT, MDU_WAIT)
//   FWD_*    : EX operand source select encodings
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MDU_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding compare for one EX source operand.
//   rs_ex_i        : source register read by the EX instruction
//   rd_mem_i/...   : destination and write-enable of the MEM instruction
//   rd_wb_i/...    : destination and write-enable of the WB instruction
//   fwd_o          : FWD_MEM, FWD_WB or FWD_RF; MEM wins as the younger result
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs_ex_i,
  input  logic [4:0] rd_mem_i,
  input  logic       regwrite_mem_i,
  input  logic [4:0] rd_wb_i,
  input  logic       regwrite_wb_i,
  output logic [1:0] fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (regwrite_mem_i && (rd_mem_i != 5'd0) && (rd_mem_i == rs_ex_i)) begin
      fwd_o = FWD_MEM;
    end else if (regwrite_wb_i && (rd_wb_i != 5'd0) && (rd_wb_i == rs_ex_i)) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32 core.
//   Inputs : ID/EX/MEM/WB register ids and write enables, load flag in EX,
//            branch redirect from EX, MDU start, data-memory handshake.
//   Outputs: per-stage stall/flush, EX forwarding selects, MDU done pulse,
//            saturating count of cycles with the PC held.
// All control outputs are forced low while rst is high.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_id_i,
  input  logic [4:0]       rs2_id_i,
  input  logic             use_rs1_i,
  input  logic             use_rs2_i,
  input  logic [4:0]       rs1_ex_i,
  input  logic [4:0]       rs2_ex_i,
  input  logic [4:0]       rd_ex_i,
  input  logic             memread_ex_i,
  input  logic             regwrite_ex_i,
  input  logic [4:0]       rd_mem_i,
  input  logic             regwrite_mem_i,
  input  logic [4:0]       rd_wb_i,
  input  logic             regwrite_wb_i,
  input  logic             redirect_ex_i,
  input  logic             mdu_start_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             stall_ex_o,
  output logic             stall_mem_o,
  output logic             flush_id_o,
  output logic             flush_ex_o,
  output logic             flush_mem_o,
  output logic             flush_wb_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             mdu_done_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int MDU_W = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;

  // A start seen in RUN already spends that cycle executing, so the wait
  // state needs one cycle less than a start held over a memory wait.
  localparam logic [MDU_W-1:0] MDU_LOAD_RUN  = MDU_W'(MDU_LAT - 2);
  localparam logic [MDU_W-1:0] MDU_LOAD_PEND = MDU_W'(MDU_LAT - 1);

  state_e             state_q, state_d;
  logic [MDU_W-1:0]   mdu_cnt_q, mdu_cnt_d;
  logic               mdu_pend_q, mdu_pend_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic [1:0]         fwd_a_raw, fwd_b_raw;
  logic               load_use;
  logic               mem_miss;

  fwd_unit u_fwd_a (
    .rs_ex_i        (rs1_ex_i),
    .rd_mem_i       (rd_mem_i),
    .regwrite_mem_i (regwrite_mem_i),
    .rd_wb_i        (rd_wb_i),
    .regwrite_wb_i  (regwrite_wb_i),
    .fwd_o          (fwd_a_raw)
  );

  fwd_unit u_fwd_b (
    .rs_ex_i        (rs2_ex_i),
    .rd_mem_i       (rd_mem_i),
    .regwrite_mem_i (regwrite_mem_i),
    .rd_wb_i        (rd_wb_i),
    .regwrite_wb_i  (regwrite_wb_i),
    .fwd_o          (fwd_b_raw)
  );

  always_comb begin
    load_use = memread_ex_i && regwrite_ex_i && (rd_ex_i != 5'd0) &&
               ((use_rs1_i && (rs1_id_i == rd_ex_i)) ||
                (use_rs2_i && (rs2_id_i == rd_ex_i)));
    mem_miss = dmem_req_i && !dmem_ready_i;
  end

  always_comb begin
    state_d     = state_q;
    mdu_cnt_d   = mdu_cnt_q;
    mdu_pend_d  = mdu_pend_q;
    stall_if_o  = 1'b0;
    stall_id_o  = 1'b0;
    stall_ex_o  = 1'b0;
    stall_mem_o = 1'b0;
    flush_id_o  = 1'b0;
    flush_ex_o  = 1'b0;
    flush_mem_o = 1'b0;
    flush_wb_o  = 1'b0;
    mdu_done_o  = 1'b0;
    fwd_a_o     = fwd_a_raw;
    fwd_b_o     = fwd_b_raw;

    unique case (state_q)
      ST_RUN: begin
        if (mem_miss) begin
          // Memory wait wins; an MDU start arriving now is replayed afterwards.
          state_d = ST_MEM_WAIT;
          if (mdu_start_i) begin
            mdu_pend_d = 1'b1;
          end
        end else if (mdu_start_i) begin
          state_d     = ST_MDU_WAIT;
          mdu_cnt_d   = MDU_LOAD_RUN;
          stall_if_o  = 1'b1;
          stall_id_o  = 1'b1;
          stall_ex_o  = 1'b1;
          flush_mem_o = 1'b1;
        end

        if (redirect_ex_i) begin
          flush_id_o = 1'b1;
          flush_ex_o = 1'b1;
        end else if (load_use && !(mdu_start_i && !mem_miss)) begin
          stall_if_o = 1'b1;
          stall_id_o = 1'b1;
          flush_ex_o = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        stall_if_o  = 1'b1;
        stall_id_o  = 1'b1;
        stall_ex_o  = 1'b1;
        stall_mem_o = 1'b1;
        flush_wb_o  = 1'b1;
        if (dmem_ready_i) begin
          if (mdu_pend_q) begin
            state_d    = ST_MDU_WAIT;
            mdu_cnt_d  = MDU_LOAD_PEND;
            mdu_pend_d = 1'b0;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_MDU_WAIT: begin
        stall_if_o  = 1'b1;
        stall_id_o  = 1'b1;
        stall_ex_o  = 1'b1;
        flush_mem_o = 1'b1;
        if (mdu_cnt_q == '0) begin
          mdu_done_o = 1'b1;
          state_d    = ST_RUN;
        end else begin
          mdu_cnt_d = mdu_cnt_q - MDU_W'(1);
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (rst) begin
      stall_if_o  = 1'b0;
      stall_id_o  = 1'b0;
      stall_ex_o  = 1'b0;
      stall_mem_o = 1'b0;
      flush_id_o  = 1'b0;
      flush_ex_o  = 1'b0;
      flush_mem_o = 1'b0;
      flush_wb_o  = 1'b0;
      mdu_done_o  = 1'b0;
      fwd_a_o     = '0;
      fwd_b_o     = '0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_if_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      mdu_cnt_q   <= '0;
      mdu_pend_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mdu_cnt_q   <= mdu_cnt_d;
      mdu_pend_q  <= mdu_pend_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: the stimulus process drives one vector per
// cycle and queues its hand-computed response; a monitor on the falling edge
// pops and compares. A second instance with a 4-bit counter checks saturation.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic       use1;
    logic       use2;
    logic [4:0] rs1_ex;
    logic [4:0] rs2_ex;
    logic [4:0] rd_ex;
    logic       memread;
    logic       rw_ex;
    logic [4:0] rd_mem;
    logic       rw_mem;
    logic [4:0] rd_wb;
    logic       rw_wb;
    logic       redirect;
    logic       mdu_start;
    logic       dmem_req;
    logic       dmem_ready;
  } stim_t;

  typedef struct packed {
    logic [3:0]  stl;   // {if, id, ex, mem}
    logic [3:0]  fl;    // {id, ex, mem, wb}
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        done;
    logic [31:0] cnt;
    logic [3:0]  c4;
  } exp_t;

  logic  clk;
  stim_t s;

  logic        stall_if, stall_id, stall_ex, stall_mem;
  logic        flush_id, flush_ex, flush_mem, flush_wb;
  logic [1:0]  fwd_a, fwd_b;
  logic        mdu_done;
  logic [31:0] stall_cnt;

  logic        s4_if, s4_id, s4_ex, s4_mem;
  logic        f4_id, f4_ex, f4_mem, f4_wb;
  logic [1:0]  fa4, fb4;
  logic        done4;
  logic [3:0]  cnt4;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;

  hazard_ctrl #(.MDU_LAT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(s.rst),
    .rs1_id_i(s.rs1_id), .rs2_id_i(s.rs2_id),
    .use_rs1_i(s.use1), .use_rs2_i(s.use2),
    .rs1_ex_i(s.rs1_ex), .rs2_ex_i(s.rs2_ex), .rd_ex_i(s.rd_ex),
    .memread_ex_i(s.memread), .regwrite_ex_i(s.rw_ex),
    .rd_mem_i(s.rd_mem), .regwrite_mem_i(s.rw_mem),
    .rd_wb_i(s.rd_wb), .regwrite_wb_i(s.rw_wb),
    .redirect_ex_i(s.redirect), .mdu_start_i(s.mdu_start),
    .dmem_req_i(s.dmem_req), .dmem_ready_i(s.dmem_ready),
    .stall_if_o(stall_if), .stall_id_o(stall_id),
    .stall_ex_o(stall_ex), .stall_mem_o(stall_mem),
    .flush_id_o(flush_id), .flush_ex_o(flush_ex),
    .flush_mem_o(flush_mem), .flush_wb_o(flush_wb),
    .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
    .mdu_done_o(mdu_done), .stall_cnt_o(stall_cnt)
  );

  hazard_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(s.rst),
    .rs1_id_i(s.rs1_id), .rs2_id_i(s.rs2_id),
    .use_rs1_i(s.use1), .use_rs2_i(s.use2),
    .rs1_ex_i(s.rs1_ex), .rs2_ex_i(s.rs2_ex), .rd_ex_i(s.rd_ex),
    .memread_ex_i(s.memread), .regwrite_ex_i(s.rw_ex),
    .rd_mem_i(s.rd_mem), .regwrite_mem_i(s.rw_mem),
    .rd_wb_i(s.rd_wb), .regwrite_wb_i(s.rw_wb),
    .redirect_ex_i(s.redirect), .mdu_start_i(s.mdu_start),
    .dmem_req_i(s.dmem_req), .dmem_ready_i(s.dmem_ready),
    .stall_if_o(s4_if), .stall_id_o(s4_id),
    .stall_ex_o(s4_ex), .stall_mem_o(s4_mem),
    .flush_id_o(f4_id), .flush_ex_o(f4_ex),
    .flush_mem_o(f4_mem), .flush_wb_o(f4_wb),
    .fwd_a_o(fa4), .fwd_b_o(fb4),
    .mdu_done_o(done4), .stall_cnt_o(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [3:0] stl, input logic [3:0] fl,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input logic done, input int cnt);
    exp_t e;
    e.stl  = stl;
    e.fl   = fl;
    e.fa   = fa;
    e.fb   = fb;
    e.done = done;
    e.cnt  = 32'(cnt);
    e.c4   = (cnt > 15) ? 4'd15 : 4'(cnt);
    return e;
  endfunction

  task automatic step(input stim_t st, input exp_t e);
    @(posedge clk);
    #1;
    s = st;
    sb.push_back(e);
  endtask

  // Monitor: one response per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [12:0] act_ctl, exp_ctl, act4_ctl;
      e        = sb.pop_front();
      act_ctl  = {stall_if, stall_id, stall_ex, stall_mem,
                  flush_id, flush_ex, flush_mem, flush_wb, fwd_a, fwd_b, mdu_done};
      act4_ctl = {s4_if, s4_id, s4_ex, s4_mem,
                  f4_id, f4_ex, f4_mem, f4_wb, fa4, fb4, done4};
      exp_ctl  = {e.stl, e.fl, e.fa, e.fb, e.done};
      checks++;
      if (act_ctl !== exp_ctl) begin
        errors++;
        $display("FAIL ctl vec %0d got %b exp %b (stl4 fl4 fa2 fb2 done)", vec_no, act_ctl, exp_ctl);
      end
      checks++;
      if (stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL stall_cnt vec %0d got %0d exp %0d", vec_no, stall_cnt, e.cnt);
      end
      checks++;
      if (act4_ctl !== exp_ctl) begin
        errors++;
        $display("FAIL ctl_w4 vec %0d got %b exp %b", vec_no, act4_ctl, exp_ctl);
      end
      checks++;
      if (cnt4 !== e.c4) begin
        errors++;
        $display("FAIL stall_cnt_w4 vec %0d got %0d exp %0d", vec_no, cnt4, e.c4);
      end
      vec_no++;
    end
  end

  initial begin
    stim_t idle, v;
    idle = '0;
    s = idle;
    s.rst = 1'b1;

    // Reset
    v = idle; v.rst = 1'b1;
    step(v, mk(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 0));
    step(v, mk(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 0));

    // Load-use on rs1: one stall cycle then clear
    v = idle; v.memread = 1; v.rw_ex = 1; v.rd_ex = 5; v.rs1_id = 5; v.use1 = 1;
    step(v, mk(4'b1100, 4'b0100, 2'b00, 2'b00, 1'b0, 0));
    step(idle, mk(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 1));
    // Load-use on rs2 (rs1 matches but is unused)
    v = idle; v.memread = 1; v.rw_ex = 1; v.rd_ex = 5; v.rs1_id = 5; v.rs2_id = 5; v.use2 = 1;
    step(v, mk(4'b1100, 4'b0100, 2'b00, 2'b00, 1'b0, 1));
    step(idle, mk(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 2));
    // Load to x0 never stalls; non-writing load never stalls
    v = idle; v.memread = 1; v.rw_ex = 1; v.rd_ex = 0; v.rs1_id = 0; v.use1 = 1;
    step(v, mk(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 2));
    v = idle; v.memread = 1; v.rw_ex = 0; v.rd_ex = 5; v.rs1_id = 5; v.use1 = 1;
    step(v, mk(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 2));

    // Redirect suppresses load-use
    v = idle; v.memread = 1; v.rw_ex = 1; v.rd_ex = 5; v.rs1_id = 5; v.use1 = 1; v.redirect = 1;
    step(v, mk(4'b0000, 4'b1100, 2'b00, 2'b00, 1'b0, 2));
    step(idle, mk(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 2));

    // MDU: start at t, done at t+3, RUN at t+4; redirect/start ignored while waiting
    v = idle; v.mdu_start = 1;
    step(v, mk(4'b1110, 4'b0010, 2'b00, 2'b00, 1'b0, 2));
    v = idle; v.mdu_start = 1; v.redirect = 1; v.rs1_ex = 3; v.rd_mem = 3; v.rw_mem = 1;
    step(v, mk(4'b1110, 4'b0010, 2'b10, 2'b00, 1'b0, 3));
    step(idle, mk(4'b1110, 4'b0010, 2'b00, 2'b00, 1'b0, 4));
    step(idle, mk(4'b1110, 4'b0010, 2'b00, 2'b00, 1'b1, 5));
    step(idle, mk(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 6));

    // Memory wait with MDU start at its first cycle: 3 MEM_WAIT + 4 MDU_WAIT
    v = idle; v.dmem_req = 1; v.mdu_start = 1;
    step(v, mk(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 6));
    v = idle; v.dmem_req = 1;
    step(v, mk(4'b1111, 4'b0001, 2'b00, 2'b00, 1'b0, 6));
    step(v, mk(4'b1111, 4'b0001, 2'b00, 2'b00, 1'b0, 7));
    v.dmem_ready = 1;
    step(v, mk(4'b1111, 4'b0001, 2'b00, 2'b00, 1'b0, 8));
    step(idle, mk(4'b1110, 4'b0010, 2'b00, 2'b00, 1'b0, 9));
    step(idle, mk(4'b1110, 4'b0010, 2'b00, 2'b00, 1'b0, 10));
    step(idle, mk(4'b1110, 4'b0010, 2'b00, 2'b00, 1'b0, 11));
    step(idle, mk(4'b1110, 4'b0010, 2'b00, 2'b00, 1'b1, 12));
    step(idle, mk(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 13));

    // Forwarding
    v = idle; v.rd_mem = 7; v.rw_mem = 1; v.rd_wb = 7; v.rw_wb = 1; v.rs1_ex = 7; v.rs2_ex = 7;
    step(v, mk(4'b0000, 4'b0000, 2'b10, 2'b10, 1'b0, 13));
    v.rd_mem = 0;
    step(v, mk(4'b0000, 4'b0000, 2'b01, 2'b01, 1'b0, 13));
    v.rd_wb = 0; v.rs1_ex = 0; v.rs2_ex = 0;
    step(v, mk(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 13));
    v = idle; v.rd_mem = 7; v.rw_mem = 0; v.rd_wb = 7; v.rw_wb = 1; v.rs1_ex = 7; v.rs2_ex = 9;
    step(v, mk(4'b0000, 4'b0000, 2'b01, 2'b00, 1'b0, 13));
    v.rd_mem = 9; v.rw_mem = 1;
    step(v, mk(4'b0000, 4'b0000, 2'b01, 2'b10, 1'b0, 13));

    // Reset mid MDU_WAIT
    v = idle; v.mdu_start = 1;
    step(v, mk(4'b1110, 4'b0010, 2'b00, 2'b00, 1'b0, 13));
    step(idle, mk(4'b1110, 4'b0010, 2'b00, 2'b00, 1'b0, 14));
    v = idle; v.rst = 1; v.rd_mem = 4; v.rw_mem = 1; v.rs1_ex = 4;
    step(v, mk(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 15));
    step(idle, mk(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 0));
    v = idle; v.memread = 1; v.rw_ex = 1; v.rd_ex = 5; v.rs1_id = 5; v.use1 = 1;
    step(v, mk(4'b1100, 4'b0100, 2'b00, 2'b00, 1'b0, 0));
    step(idle, mk(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 1));

    // Long memory wait: 4-bit counter saturates at 15
    v = idle; v.dmem_req = 1;
    step(v, mk(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 1));
    for (int i = 0; i < 20; i++) begin
      step(v, mk(4'b1111, 4'b0001, 2'b00, 2'b00, 1'b0, 1 + i));
    end
    v.dmem_ready = 1;
    step(v, mk(4'b1111, 4'b0001, 2'b00, 2'b00, 1'b0, 21));
    step(idle, mk(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 22));

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
